// File: rtl/video_capture_pkg.sv
// Shared definitions for the 640x480 video path: standard timing constants,
// capture FSM states and the RGB-to-palette packing that pairs with the generator's expansion.
package video_capture_pkg;

    localparam int H_VISIBLE_STD = 640;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_WIDTH  = 96;
    localparam int H_BACK_PORCH  = 48;
    localparam int H_TOTAL       = H_VISIBLE_STD + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;

    localparam int V_VISIBLE_STD = 480;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_WIDTH  = 2;
    localparam int V_BACK_PORCH  = 33;
    localparam int V_TOTAL       = V_VISIBLE_STD + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    // Bit positions of the timing signals inside the edge detector's vector
    localparam int TIM_HBLANK = 0;
    localparam int TIM_VBLANK = 1;
    localparam int TIM_HSYNC  = 2;
    localparam int TIM_VSYNC  = 3;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_BLANK   = 2'd2
    } capture_state_t;

    // Black stays 0; any other colour that truncates to 0 is nudged to 1 so it is not mistaken for black.
    function automatic logic [7:0] pack_palette(input logic [7:0] r, input logic [7:0] g,
                                                input logic [7:0] b);
        logic [7:0] packed_value;
        packed_value = {r[7:4], g[7:4]};
        if ((r | g | b) == 8'd0) begin
            return 8'd0;
        end
        if (packed_value == 8'd0) begin
            return 8'd1;
        end
        return packed_value;
    endfunction

endpackage

// File: rtl/video_edge_detect.sv
// Pixel-qualified sampling of the four timing inputs with rise/fall pulses.
// Pulses are valid only in the cycle after a qualified sample (strobe high).
module video_edge_detect (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic [3:0] timing,
    output logic [3:0] level,
    output logic [3:0] rise,
    output logic [3:0] fall,
    output logic       strobe
);

    logic [3:0] prev_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level    <= '0;
            prev_reg <= '0;
            strobe   <= 1'b0;
        end else begin
            strobe <= ce_pix;
            if (ce_pix) begin
                level    <= timing;
                prev_reg <= level;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            assign rise[gi] = strobe & level[gi] & ~prev_reg[gi];
            assign fall[gi] = strobe & ~level[gi] & prev_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/video_capture.sv
// Video receive path: measures frame geometry, packs active pixels to palette
// indices for a framebuffer write port, and tracks lock and frame statistics.
module video_capture #(
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480,
    parameter int ADDR_W      = 19,
    parameter int LOCK_FRAMES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce_pix,
    input  logic              HBlank,
    input  logic              VBlank,
    input  logic              HSync,
    input  logic              VSync,
    input  logic [7:0]        videor,
    input  logic [7:0]        videog,
    input  logic [7:0]        videob,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [7:0]        writeValue,
    output logic              writeEnable,
    output logic              locked,
    output logic [15:0]       frameCount,
    output logic [9:0]        lineLength,
    output logic [9:0]        lineCount,
    output logic              overflow
);

    import video_capture_pkg::*;

    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [ADDR_W:0] FRAME_END = (ADDR_W + 1)'(H_VISIBLE * V_VISIBLE);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       strobe;

    video_edge_detect u_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .ce_pix (ce_pix),
        .timing ({VSync, HSync, VBlank, HBlank}),
        .level  (level),
        .rise   (rise),
        .fall   (fall),
        .strobe (strobe)
    );

    logic unused_timing;
    assign unused_timing = ^{level[TIM_VSYNC], level[TIM_HSYNC], rise[TIM_HSYNC],
                             fall[TIM_HSYNC], fall[TIM_VSYNC], fall[TIM_HBLANK]};

    logic [7:0]        r_reg, g_reg, b_reg;
    capture_state_t    state_reg;
    logic [ADDR_W:0]   addr_reg;
    logic [9:0]        pix_cnt_reg;
    logic [9:0]        line_cnt_reg;
    logic              vsync_seen_reg;
    logic [GOOD_W-1:0] good_cnt_reg;

    logic              active, restart, frame_check, frame_good, do_pixel, addr_full;
    logic [ADDR_W:0]   cur_addr;
    logic [9:0]        cur_pix;
    logic [GOOD_W-1:0] good_next;

    // A VBlank fall restarts capture from any state; the sample carrying it may already be pixel 0.
    always_comb begin
        active      = ~level[TIM_HBLANK] & ~level[TIM_VBLANK];
        restart     = fall[TIM_VBLANK];
        frame_check = restart && (state_reg != ST_SEARCH);
        frame_good  = (state_reg == ST_BLANK) && (line_cnt_reg == 10'(V_VISIBLE)) &&
                      (lineLength == 10'(H_VISIBLE)) && vsync_seen_reg;
        if (!frame_good) begin
            good_next = '0;
        end else if (good_cnt_reg == GOOD_W'(LOCK_FRAMES)) begin
            good_next = good_cnt_reg;
        end else begin
            good_next = good_cnt_reg + 1'b1;
        end
        cur_addr  = restart ? '0 : addr_reg;
        cur_pix   = restart ? '0 : pix_cnt_reg;
        do_pixel  = strobe && active && (restart || (state_reg == ST_CAPTURE));
        addr_full = (cur_addr >= FRAME_END);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reg          <= '0;
            g_reg          <= '0;
            b_reg          <= '0;
            state_reg      <= ST_SEARCH;
            addr_reg       <= '0;
            pix_cnt_reg    <= '0;
            line_cnt_reg   <= '0;
            vsync_seen_reg <= 1'b0;
            good_cnt_reg   <= '0;
            writeAddress   <= '0;
            writeValue     <= '0;
            writeEnable    <= 1'b0;
            locked         <= 1'b0;
            frameCount     <= '0;
            lineLength     <= '0;
            lineCount      <= '0;
            overflow       <= 1'b0;
        end else begin
            writeEnable <= 1'b0;
            if (ce_pix) begin
                r_reg <= videor;
                g_reg <= videog;
                b_reg <= videob;
            end
            if (strobe) begin
                case (state_reg)
                    ST_CAPTURE: begin
                        // Line accounting precedes the move to BLANK when both edges coincide
                        if (rise[TIM_HBLANK]) begin
                            lineLength  <= pix_cnt_reg;
                            pix_cnt_reg <= '0;
                            if (pix_cnt_reg != '0 && line_cnt_reg != CNT_MAX) begin
                                line_cnt_reg <= line_cnt_reg + 1'b1;
                            end
                        end
                        if (rise[TIM_VBLANK]) begin
                            state_reg <= ST_BLANK;
                        end
                    end
                    ST_BLANK: begin
                        if (rise[TIM_VSYNC]) begin
                            vsync_seen_reg <= 1'b1;
                        end
                    end
                    default: ;
                endcase

                if (frame_check) begin
                    good_cnt_reg <= good_next;
                    locked       <= (good_next == GOOD_W'(LOCK_FRAMES));
                    frameCount   <= frameCount + 16'd1;
                    lineCount    <= line_cnt_reg;
                end

                if (restart) begin
                    state_reg      <= ST_CAPTURE;
                    addr_reg       <= '0;
                    pix_cnt_reg    <= '0;
                    line_cnt_reg   <= '0;
                    vsync_seen_reg <= 1'b0;
                end

                if (do_pixel) begin
                    pix_cnt_reg <= (cur_pix == CNT_MAX) ? cur_pix : cur_pix + 1'b1;
                    if (addr_full) begin
                        overflow <= 1'b1;
                    end else begin
                        writeEnable  <= 1'b1;
                        writeAddress <= cur_addr[ADDR_W-1:0];
                        writeValue   <= pack_palette(r_reg, g_reg, b_reg);
                        addr_reg     <= cur_addr + 1'b1;
                    end
                end
            end
        end
    end

endmodule
